// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze generation, stall watchdog and perf counters.
// Define HAZARD_FORWARD_EN when the datapath has forwarding paths (only load-use then stalls).
module hazard_ctrl #(
    parameter int STALL_MAX = 7,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_dec,
    input  logic             reg_write_ex,
    input  logic             mem_read_ex,
    input  logic [4:0]       write_reg_ex,
    input  logic             reg_write_mem,
    input  logic [4:0]       write_reg_mem,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    output logic             stall,
    output logic             flush,
    output logic             freeze,
    output logic [2:0]       cycle_count,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             stall_timeout
);
    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_FREEZE} state_t;

    localparam logic [2:0]       LP_SMAX = 3'(STALL_MAX);
    localparam logic [CNT_W-1:0] LP_CMAX = '1;
    localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, r_ret, w_next, w_next_ret;
    logic [2:0]       r_cc;
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
    logic             r_timeout;

    logic [4:0] w_rs1, w_rs2;
    logic [6:0] w_op;
    logic       w_use1, w_use2, w_match_ex, w_match_mem, w_hazard;
    logic       w_unused;

    assign w_rs1 = instr_dec[19:15];
    assign w_rs2 = instr_dec[24:20];
    assign w_op  = instr_dec[6:0];

    assign w_use1 = !(w_op == 7'b0110111 || w_op == 7'b0010111 || w_op == 7'b1101111);
    assign w_use2 = (w_op == 7'b0110011 || w_op == 7'b0100011 || w_op == 7'b1100011);

    assign w_match_ex  = reg_write_ex && (write_reg_ex != 5'd0) &&
                         ((w_use1 && write_reg_ex == w_rs1) || (w_use2 && write_reg_ex == w_rs2));
    assign w_match_mem = reg_write_mem && (write_reg_mem != 5'd0) &&
                         ((w_use1 && write_reg_mem == w_rs1) || (w_use2 && write_reg_mem == w_rs2));

`ifdef HAZARD_FORWARD_EN
    assign w_hazard = w_match_ex && mem_read_ex;
`else
    assign w_hazard = w_match_ex || w_match_mem;
`endif

    assign w_unused = ^{instr_dec[31:25], instr_dec[14:7], mem_read_ex, w_match_mem};

    // A FLUSH cycle has a bubble in decode, so any apparent hazard is ignored.
    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
        if (reset) begin
            if (mem_busy)             freeze = 1'b1;
            else if (branch_taken_ex) flush  = 1'b1;
            else                      stall  = w_hazard && (r_state != S_FLUSH);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_ret = r_ret;
        case (r_state)
            S_RUN, S_STALL: begin
                if (mem_busy) begin
                    w_next     = S_FREEZE;
                    w_next_ret = r_state;
                end
                else if (flush) w_next = S_FLUSH;
                else if (stall) w_next = S_STALL;
                else            w_next = S_RUN;
            end
            S_FLUSH: begin
                if (mem_busy) begin
                    w_next     = S_FREEZE;
                    w_next_ret = S_RUN;
                end
                else w_next = S_RUN;
            end
            S_FREEZE: begin
                // A branch held in EX across the freeze flushes on the first free cycle.
                if (!mem_busy) w_next = flush ? S_FLUSH : r_ret;
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_RUN;
            r_ret          <= S_RUN;
            r_cc           <= 3'd0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
            r_timeout      <= 1'b0;
        end
        else begin
            r_state <= w_next;
            r_ret   <= w_next_ret;
            if (stall) begin
                if (r_cc != LP_SMAX)           r_cc <= r_cc + 3'd1;
                if (r_stall_cycles != LP_CMAX) r_stall_cycles <= r_stall_cycles + LP_ONE;
                if (r_cc == LP_SMAX)           r_timeout <= 1'b1;
            end
            else if (!freeze) begin
                r_cc <= 3'd0;
            end
            if (flush && r_flush_events != LP_CMAX) r_flush_events <= r_flush_events + LP_ONE;
        end
    end

    assign cycle_count   = r_cc;
    assign stall_cycles  = r_stall_cycles;
    assign flush_events  = r_flush_events;
    assign stall_timeout = r_timeout;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It watches the instruction in decode and the producers in execute and memory, and drives the `stall`, `flush` and `cycle_count` inputs of the decode/execute pipeline register. It also drives the fetch/decode register and the PC enable. A `freeze` output halts the whole pipeline while data memory is busy. Two saturating performance counters track stall cycles and flush events.

## Interface
- `STALL_MAX`, default 7: saturation value of `cycle_count`; also the watchdog limit.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `instr_dec` input 32: instruction currently in decode.
- `reg_write_ex` input 1: the EX instruction writes the register file.
- `mem_read_ex` input 1: the EX instruction is a load.
- `write_reg_ex` input 5: EX destination register.
- `reg_write_mem` input 1: the MEM instruction writes the register file.
- `write_reg_mem` input 5: MEM destination register.
- `branch_taken_ex` input 1: a branch or jump in EX redirects the PC.
- `mem_busy` input 1: data memory has not completed its access.
- `stall` output 1: hold PC and fetch/decode; insert a bubble into execute.
- `flush` output 1: kill the wrong-path instructions in fetch and decode.
- `freeze` output 1: hold every pipeline register.
- `cycle_count` output 3: consecutive stall cycles before the current cycle, saturating at `STALL_MAX`.
- `stall_cycles` output `CNT_W`: total stall cycles, saturating.
- `flush_events` output `CNT_W`: total flushes, saturating.
- `stall_timeout` output 1: sticky flag set when a stall exceeds `STALL_MAX` cycles.

## Operation
- Register fields: `rs1` = `instr_dec[19:15]`, `rs2` = `instr_dec[24:20]`, opcode = `instr_dec[6:0]`.
- `use1` is 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111), and 1 otherwise.
- `use2` is 1 only for R-type (0110011), S-type (0100011) and B-type (1100011).
- `match_x(p)` = `reg_write_p` and `write_reg_p` != 0 and ((`use1` and `write_reg_p` == `rs1`) or (`use2` and `write_reg_p` == `rs2`)).
- `hazard` with forwarding = `match_x(ex)` and `mem_read_ex`, i.e. load-use only.
- Output priority:
  1. `mem_busy`=1: `freeze`=1, `stall`=0, `flush`=0.
  2. Otherwise `branch_taken_ex`=1: `flush`=1, `stall`=0. A taken branch cancels any hazard, because the decode instruction is wrong-path.
  3. Otherwise `stall` = `hazard`.
- FSM states:
  - RUN: `stall`=1 → STALL; `flush`=1 → FLUSH; `mem_busy`=1 → FREEZE.
  - STALL: stays while `stall`=1; returns to RUN when `stall`=0; `flush`=1 → FLUSH; `mem_busy`=1 → FREEZE.
  - FLUSH: always one cycle. In this cycle `stall` is forced to 0, since decode holds a bubble. Then → RUN, or → FREEZE if `mem_busy`=1.
  - FREEZE: stays while `mem_busy`=1. On exit it returns to the state held before freezing (RUN or STALL).
- `cycle_count`:
  - Increments each cycle that `stall`=1, saturating at `STALL_MAX`.
  - Clears on any cycle with `stall`=0 and `freeze`=0.
  - Holds during FREEZE.
- `stall_cycles` increments on each `stall`=1 cycle; `flush_events` increments on each `flush`=1 cycle. Both saturate at all-ones and hold during freeze.
- `stall_timeout` sets when `stall`=1 and `cycle_count` == `STALL_MAX`. It clears only on reset.

## Timing
- `stall`, `flush` and `freeze` are combinational from the inputs and the current state: zero latency, same cycle.
- `cycle_count`, the counters, `stall_timeout` and the state are registered and update on the edge after the event.
- Reset: state RUN; `cycle_count`=0, `stall_cycles`=0, `flush_events`=0, `stall_timeout`=0. `stall`, `flush` and `freeze` are 0 whenever `reset`=0, regardless of the other inputs.
- Reset asserted in the middle of a stall or freeze aborts it on the next edge.
- `branch_taken_ex` and `mem_busy` high together: freeze wins. The flush is issued in the first cycle after `mem_busy` falls, because the branch is still held in EX.
- A load-use stall lasts exactly 1 cycle with forwarding. The producer then moves to MEM and `hazard` clears naturally.

## Configuration
- `HAZARD_FORWARD_EN` defined: forwarding paths exist, and `hazard` = load-use only, as above.
- `HAZARD_FORWARD_EN` undefined: `hazard` = `match_x(ex)` or `match_x(mem)`, for any producer type. The register file is write-through, so:
  - a dependency on EX stalls 2 cycles;
  - a dependency on MEM stalls 1 cycle.

## Test plan
- `lw x5` in EX (`mem_read_ex`=1, `write_reg_ex`=5); `add x6,x5,x7` in decode; forwarding on → `stall`=1 for 1 cycle; `cycle_count` 0→1→0; `stall_cycles`=1.
- Same stimulus with `lui x6` in decode → `stall`=0, because `use1`=`use2`=0.
- Forwarding off: `addi x5` in EX, then `sub x8,x9,x5` in decode → `stall` for 2 cycles; `cycle_count` reads 1 then 2 before clearing.
- Hazard present and `branch_taken_ex`=1 in the same cycle → `flush`=1, `stall`=0. The next cycle is FLUSH with `stall`=0. `flush_events`=1.
- `mem_busy`=1 for 4 cycles during a 1-cycle load-use stall → `freeze`=1 and `stall`=0 for 4 cycles; `cycle_count` holds; the stall resumes afterwards.
- Forced hazard held for 8 cycles → `cycle_count` saturates at 7 and `stall_timeout`=1. `reset`=0 for one cycle → all outputs 0.
